moosic_key_loader: RTL and testbench
====================================

Name: moosic_key_loader

Overview:
Upstream stage of locked_counter. It assembles a KEY_SIZE-bit moosic_key from NIBBLE_W-bit chunks strobed in on the dedicated input pins. A trailing XOR checksum chunk validates each load. Only a validated key is committed, replacing the flat single-cycle key register in tt_um_coloquinte_moosic and driving locked_counter's moosic_key directly.

Parameters:
KEY_SIZE, 16, committed key width; must be a multiple of NIBBLE_W.
NIBBLE_W, 4, bits accepted per strobe (matches ui_in[5:2]).
TIMEOUT, 65535, max clk cycles between strobes inside a load before abort; counter width is $clog2(TIMEOUT+1).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load_key  input  1  chunk strobe, already synchronous to clk; a chunk is taken on its rising edge
key_data  input  NIBBLE_W  chunk value, sampled in the same cycle the rising edge is detected
moosic_key  output  KEY_SIZE  committed key to locked_counter
key_valid  output  1  high once any load has committed since reset
busy  output  1  high while a load is in progress
error  output  1  sticky: last load failed its checksum or timed out

Behaviour:
- Reset (async, rst_n=0): moosic_key=0, key_valid=0, busy=0, error=0, state IDLE, shift register, running XOR and timeout counter all cleared, prev_load_key=0. Asserting reset mid-load discards the partial key.
- Strobe: rise = load_key & ~prev_load_key. prev_load_key is registered every cycle. Holding load_key high yields exactly one chunk.
- N = KEY_SIZE/NIBBLE_W data chunks. The first chunk is the MS nibble. Chunks shift in from the LSB side.
- FSM:
  - IDLE: on rise → LOAD. Capture chunk 0, xor_acc=key_data, cnt=1, clear error, timer=0.
  - LOAD: on rise, shift the chunk in, xor_acc^=key_data, cnt++. When cnt reaches N → SUM.
  - SUM: on rise, compare key_data with xor_acc.
    - Equal: next cycle moosic_key=shift register, key_valid=1, error=0 → IDLE.
    - Unequal: error=1, moosic_key unchanged → IDLE.
- Timeout: in LOAD or SUM, timer increments on every cycle without a rise and resets to 0 on each rise. When timer reaches TIMEOUT: → IDLE, error=1, partial key dropped, moosic_key unchanged.
- busy = (state != IDLE), registered.
- Latency: a commit is visible on moosic_key one clk after the cycle in which the checksum rise is detected.
- The previous key stays on moosic_key throughout a new load and after a failed or aborted load. key_valid never falls except on reset.
- A rise in the same cycle that the timeout fires: the timeout wins, that chunk is dropped, and the block returns to IDLE.
- N=1 is legal: IDLE goes directly to SUM after the first chunk.

Decomposition:
- Package moosic_pkg holds the state enum (IDLE, LOAD, SUM), KEY_SIZE/NIBBLE_W defaults, and the chunk-count function N.
- One sub-module, moosic_rise_detect (1-bit registered rising-edge detector with async active-low reset), instantiated for load_key.
- Everything else lives in moosic_key_loader, which the top instantiates in place of its key register.

Test Plan:
- Good load: reset, then strobe A,5,3,C plus checksum 0 → busy high from the first rise until commit. One cycle after the checksum rise, moosic_key=16'hA53C, key_valid=1, error=0.
- Bad checksum: after the good load, strobe 1,2,3,4 plus checksum 0 (correct is 4) → error=1, moosic_key remains A53C, key_valid=1, busy=0.
- Timeout (TIMEOUT=8): strobe 1,2, then hold load_key low for 8 cycles → on the 8th idle cycle state is IDLE, error=1, busy=0, moosic_key unchanged. A following full good load of 1,2,3,4 plus checksum 4 commits 1234 and clears error.
- Held strobe: keep load_key high for 5 cycles with key_data=F → exactly one chunk is accepted, cnt=1, still in LOAD.
- Async reset mid-load: after 3 chunks of a load, pulse rst_n low for less than a clock period between edges → all outputs go to 0 immediately without a clock edge. A subsequent good load of A,5,3,C plus checksum 0 commits A53C.
- Timeout/strobe collision: with TIMEOUT=8, drive a rise in exactly the cycle the timer hits 8 → the chunk is ignored, error=1, IDLE. The next rise starts a fresh load as chunk 0.

Source files
------------

// File: rtl/moosic_pkg.sv
// Shared types and helpers for the moosic key loader.
package moosic_pkg;

    // Loader states: waiting, collecting data chunks, awaiting checksum chunk.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUM  = 2'd2
    } state_e;

    localparam int KEY_SIZE_DEF = 16;
    localparam int NIBBLE_W_DEF = 4;

    // Number of data chunks (excluding the checksum) that make up one key.
    function automatic int chunk_count(input int key_size, input int nibble_w);
        return key_size / nibble_w;
    endfunction

endpackage

// File: rtl/moosic_rise_detect.sv
// Registered rising-edge detector for a signal already synchronous to clk.
module moosic_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // Remember last cycle's level so a held-high input yields one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/moosic_key_loader.sv
// Assembles a key from strobed chunks, validates it with a trailing XOR
// checksum chunk and commits only validated keys to moosic_key.
module moosic_key_loader
    import moosic_pkg::*;
#(
    parameter int KEY_SIZE = KEY_SIZE_DEF,
    parameter int NIBBLE_W = NIBBLE_W_DEF,
    parameter int TIMEOUT  = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_key,
    input  logic [NIBBLE_W-1:0] key_data,
    output logic [KEY_SIZE-1:0] moosic_key,
    output logic                key_valid,
    output logic                busy,
    output logic                error
);

    localparam int N  = chunk_count(KEY_SIZE, NIBBLE_W);
    localparam int CW = $clog2(N + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e              r_state;
    logic [KEY_SIZE-1:0] r_shift;
    logic [NIBBLE_W-1:0] r_xor;
    logic [CW-1:0]       r_cnt;
    logic [TW-1:0]       r_timer;
    logic [KEY_SIZE-1:0] r_key;
    logic                r_valid;
    logic                r_busy;
    logic                r_error;

    state_e              w_state_nxt;
    logic [KEY_SIZE-1:0] w_shift_nxt;
    logic [NIBBLE_W-1:0] w_xor_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [TW-1:0]       w_timer_nxt;
    logic [KEY_SIZE-1:0] w_key_nxt;
    logic                w_valid_nxt;
    logic                w_error_nxt;
    logic                w_rise;
    logic                w_timeout;
    logic [KEY_SIZE-1:0] w_shifted;

    moosic_rise_detect u_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (load_key),
        .o_rise (w_rise)
    );

    // The timer holds the number of idle cycles already elapsed since the
    // last accepted chunk; this cycle is the TIMEOUT-th one, so abort now.
    // Checked ahead of the strobe so a colliding chunk is dropped.
    assign w_timeout = (r_state != IDLE) && (r_timer == TW'(TIMEOUT - 1));

    // New chunks enter at the LSB end; the first chunk ends up most significant.
    assign w_shifted = (r_shift << NIBBLE_W) | KEY_SIZE'(key_data);

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_xor_nxt   = r_xor;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_key_nxt   = r_key;
        w_valid_nxt = r_valid;
        w_error_nxt = r_error;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = (N == 1) ? SUM : LOAD;
                    w_shift_nxt = KEY_SIZE'(key_data);
                    w_xor_nxt   = key_data;
                    w_cnt_nxt   = CW'(1);
                    w_timer_nxt = '0;
                    w_error_nxt = 1'b0;
                end
            end

            LOAD: begin
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_shift_nxt = '0;
                    w_xor_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                    w_error_nxt = 1'b1;
                end else if (w_rise) begin
                    w_shift_nxt = w_shifted;
                    w_xor_nxt   = r_xor ^ key_data;
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_timer_nxt = '0;
                    if (r_cnt == CW'(N - 1)) begin
                        w_state_nxt = SUM;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            SUM: begin
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_shift_nxt = '0;
                    w_xor_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                    w_error_nxt = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                    if (key_data == r_xor) begin
                        w_key_nxt   = r_shift;
                        w_valid_nxt = 1'b1;
                        w_error_nxt = 1'b0;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset discards any partial load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_xor   <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_key   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_xor   <= w_xor_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
            r_key   <= w_key_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_error <= w_error_nxt;
        end
    end

    assign moosic_key = r_key;
    assign key_valid  = r_valid;
    assign busy       = r_busy;
    assign error      = r_error;

endmodule

// File: tb/tb_moosic_key_loader.sv
// Self-checking bench for moosic_key_loader (KEY_SIZE=16, NIBBLE_W=4, TIMEOUT=8).
module tb_moosic_key_loader;

    localparam int KS = 16;
    localparam int NW = 4;
    localparam int TO = 8;
    localparam int N  = KS / NW;

    logic          clk;
    logic          rst_n;
    logic          load_key;
    logic [NW-1:0] key_data;
    logic [KS-1:0] moosic_key;
    logic          key_valid;
    logic          busy;
    logic          error;

    int total;
    int bad;

    moosic_key_loader #(
        .KEY_SIZE (KS),
        .NIBBLE_W (NW),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_key   (load_key),
        .key_data   (key_data),
        .moosic_key (moosic_key),
        .key_valid  (key_valid),
        .busy       (busy),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a load is a list of accepted chunks; the last one is
    // the checksum. Gap counts cycles since the last accepted chunk.
    logic          m_prev;
    logic          m_active;
    logic [NW-1:0] m_chunks[$];
    int            m_gap;
    logic [KS-1:0] m_key;
    logic          m_valid;
    logic          m_err;

    task automatic model_reset();
        m_prev   = 1'b0;
        m_active = 1'b0;
        m_chunks.delete();
        m_gap    = 0;
        m_key    = '0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
    endtask

    function automatic logic [NW-1:0] model_xor();
        logic [NW-1:0] x;
        x = '0;
        for (int i = 0; i < m_chunks.size() && i < N; i++) x ^= m_chunks[i];
        return x;
    endfunction

    task automatic model_cycle(input logic ld, input logic [NW-1:0] d);
        logic          rise;
        logic [KS-1:0] k;
        rise   = ld && !m_prev;
        m_prev = ld;
        if (m_active) begin
            m_gap++;
            if (m_gap >= TO) begin
                m_active = 1'b0;
                m_err    = 1'b1;
                m_chunks.delete();
            end else if (rise) begin
                m_chunks.push_back(d);
                m_gap = 0;
                if (m_chunks.size() == N + 1) begin
                    k = '0;
                    for (int i = 0; i < N; i++) k = (k << NW) | KS'(m_chunks[i]);
                    if (model_xor() == m_chunks[N]) begin
                        m_key   = k;
                        m_valid = 1'b1;
                        m_err   = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_active = 1'b0;
                    m_chunks.delete();
                end
            end
        end else if (rise) begin
            m_active = 1'b1;
            m_chunks.delete();
            m_chunks.push_back(d);
            m_gap = 0;
            m_err = 1'b0;
        end
    endtask

    // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic ld, input logic [NW-1:0] d);
        load_key = ld;
        key_data = d;
        model_cycle(ld, d);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NW-1:0] d);
        step(1'b1, d);
        step(1'b0, d);
    endtask

    task automatic load5(input logic [NW-1:0] c0, c1, c2, c3, cs);
        pulse(c0);
        pulse(c1);
        pulse(c2);
        pulse(c3);
        pulse(cs);
    endtask

    task automatic check(input string nm, input logic [KS-1:0] k,
                         input logic v, input logic b, input logic e);
        total++;
        if (moosic_key !== k || key_valid !== v || busy !== b || error !== e) begin
            bad++;
            $display("FAIL %s: got key=%h valid=%b busy=%b error=%b, want key=%h valid=%b busy=%b error=%b",
                     nm, moosic_key, key_valid, busy, error, k, v, b, e);
        end
    endtask

    typedef struct {
        logic          ld;
        logic [NW-1:0] d;
        logic [KS-1:0] key;
        logic          valid;
        logic          busy;
        logic          err;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int            hold;
        logic          ld;
        logic [NW-1:0] d;

        total = 0;
        bad   = 0;

        // Good load A,5,3,C + checksum 0, then bad load 1,2,3,4 + checksum 0.
        tbl[0]  = '{1'b1, 4'hA, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 4'hA, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 4'h5, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'h5, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'h3, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'h3, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 4'hC, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'hC, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 4'h0, 16'hA53C, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'h0, 16'hA53C, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'h1, 16'hA53C, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'h1, 16'hA53C, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'h2, 16'hA53C, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'h2, 16'hA53C, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 4'h3, 16'hA53C, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'h3, 16'hA53C, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 4'h4, 16'hA53C, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 4'h4, 16'hA53C, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 4'h0, 16'hA53C, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 4'h0, 16'hA53C, 1'b1, 1'b0, 1'b1};

        rst_n    = 1'b0;
        load_key = 1'b0;
        key_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].ld, tbl[i].d);
            check($sformatf("vec%0d", i), tbl[i].key, tbl[i].valid, tbl[i].busy, tbl[i].err);
        end

        // Timeout: two chunks, then load_key low; abort on the 8th idle cycle.
        pulse(4'h1);
        step(1'b1, 4'h2);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 4'h0);
        check("timeout_pre", 16'hA53C, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'h0);
        check("timeout_fire", 16'hA53C, 1'b1, 1'b0, 1'b1);
        load5(4'h1, 4'h2, 4'h3, 4'h4, 4'h4);
        check("after_timeout_load", 16'h1234, 1'b1, 1'b0, 1'b0);

        // Held strobe: five high cycles with F count as one chunk.
        for (int i = 0; i < 5; i++) step(1'b1, 4'hF);
        check("held_busy", 16'h1234, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'h0);
        pulse(4'h1);
        pulse(4'h2);
        pulse(4'h3);
        pulse(4'hF);
        check("held_commit", 16'hF123, 1'b1, 1'b0, 1'b0);

        // Async reset mid-load, between clock edges.
        pulse(4'hA);
        pulse(4'h5);
        pulse(4'h3);
        check("pre_async_rst", 16'hF123, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        load5(4'hA, 4'h5, 4'h3, 4'hC, 4'h0);
        check("post_rst_load", 16'hA53C, 1'b1, 1'b0, 1'b0);

        // Gap of 7 is accepted; a rise on the 8th idle cycle loses to the timeout.
        step(1'b1, 4'h1);
        for (int i = 0; i < TO - 2; i++) step(1'b0, 4'h0);
        step(1'b1, 4'h2);
        check("gap7_ok", 16'hA53C, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 4'h0);
        step(1'b1, 4'h9);
        check("collision", 16'hA53C, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'h0);
        load5(4'h9, 4'h8, 4'h7, 4'h6, 4'h0);
        check("after_collision", 16'h9876, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold > 0) begin
                ld = 1'b0;
                hold--;
            end else if ($urandom_range(0, 39) == 0) begin
                ld   = 1'b0;
                hold = $urandom_range(5, 12);
            end else begin
                ld = 1'($urandom_range(0, 1));
            end
            if (m_active && m_chunks.size() == N && $urandom_range(0, 1) == 1)
                d = model_xor();
            else
                d = NW'($urandom_range(0, 15));
            step(ld, d);
            check($sformatf("rand%0d", c), m_key, m_valid, m_active, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

endmodule
